// File: rtl/coeff_table_loader_if.sv
// Bundles the load stream, read port and status of coeff_table_loader.
// The master side drives the stream and read address; the slave side is the table itself.
interface coeff_table_loader_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [5:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              table_valid;
  logic              chk_err;

  modport master (
    output start, s_valid, s_data, rd_addr,
    input  s_ready, rd_data, busy, done, table_valid, chk_err
  );

  modport slave (
    input  start, s_valid, s_data, rd_addr,
    output s_ready, rd_data, busy, done, table_valid, chk_err
  );
endinterface

// File: rtl/coeff_table_loader.sv
// Stream-loaded coefficient register file with a combinational read port for the evaluator.
// Define COEFF_CHECKSUM_EN to require a trailing sum word before the table is marked valid.
module coeff_table_loader #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  coeff_table_loader_if.slave bus
);
  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [5:0]       DEPTH_ADDR = 6'(DEPTH);

`ifdef COEFF_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CHECK = 2'd2} state_t;

  function automatic logic [DATA_W-1:0] f_sum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] word);
    f_sum_add = acc + word;
  endfunction
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1} state_t;
`endif

  state_t            r_state;
  state_t            w_next_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_done;
  logic              r_table_valid;
  logic              w_s_ready;
  logic              w_load_wr;
  logic [DATA_W-1:0] w_rd_data;
`ifdef COEFF_CHECKSUM_EN
  logic              w_check_wr;
  logic              r_chk_err;
  logic [DATA_W-1:0] r_sum;
`else
  logic              w_last_wr;
`endif

  // s_ready/busy depend on registered state only, never on s_valid
  assign w_s_ready = (r_state != ST_IDLE);

  // Next-state decode; start always wins over a same-cycle handshake
  always_comb begin
    w_next_state = r_state;
    w_load_wr    = 1'b0;
`ifdef COEFF_CHECKSUM_EN
    w_check_wr   = 1'b0;
`else
    w_last_wr    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_LOAD;
        else           w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (bus.start) begin
          w_next_state = ST_LOAD;
        end else if (bus.s_valid) begin
          w_load_wr = 1'b1;
          if (r_wr_ptr == LAST_PTR) begin
`ifdef COEFF_CHECKSUM_EN
            w_next_state = ST_CHECK;
`else
            w_last_wr    = 1'b1;
            w_next_state = ST_IDLE;
`endif
          end else begin
            w_next_state = ST_LOAD;
          end
        end else begin
          w_next_state = ST_LOAD;
        end
      end
`ifdef COEFF_CHECKSUM_EN
      ST_CHECK: begin
        if (bus.start) begin
          w_next_state = ST_LOAD;
        end else if (bus.s_valid) begin
          w_check_wr   = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_CHECK;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Write pointer: cleared on every start, advanced per accepted coefficient
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_wr_ptr <= {PTR_W{1'b0}};
    else if (bus.start) r_wr_ptr <= {PTR_W{1'b0}};
    else if (w_load_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
  end

  // Coefficient storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {DATA_W{1'b0}};
    end else if (w_load_wr) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  // Completion pulse and table status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done        <= 1'b0;
      r_table_valid <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
      r_chk_err     <= 1'b0;
      r_sum         <= {DATA_W{1'b0}};
`endif
    end else begin
`ifdef COEFF_CHECKSUM_EN
      r_done <= w_check_wr;
      if (bus.start) begin
        r_table_valid <= 1'b0;
        r_chk_err     <= 1'b0;
        r_sum         <= {DATA_W{1'b0}};
      end else begin
        if (w_load_wr) r_sum <= f_sum_add(r_sum, bus.s_data);
        if (w_check_wr) begin
          if (bus.s_data == r_sum) r_table_valid <= 1'b1;
          else                     r_chk_err     <= 1'b1;
        end
      end
`else
      r_done <= w_last_wr;
      if (bus.start)      r_table_valid <= 1'b0;
      else if (w_last_wr) r_table_valid <= 1'b1;
`endif
    end
  end

  // Combinational read; addresses beyond the table read as zero
  always_comb begin
    if (bus.rd_addr < DEPTH_ADDR) w_rd_data = r_mem[bus.rd_addr[PTR_W-1:0]];
    else                          w_rd_data = {DATA_W{1'b0}};
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.busy        = w_s_ready;
  assign bus.done        = r_done;
  assign bus.table_valid = r_table_valid;
  assign bus.rd_data     = w_rd_data;
`ifdef COEFF_CHECKSUM_EN
  assign bus.chk_err     = r_chk_err;
`else
  assign bus.chk_err     = 1'b0;
`endif
endmodule

// File: tb/tb_coeff_table_loader.sv
// Scoreboard bench for coeff_table_loader: accepted words are queued and checked on done.
// Build with COEFF_CHECKSUM_EN defined to exercise the checksum word.
module tb_coeff_table_loader;
  localparam int DEPTH = 16;
  localparam int DW    = 32;
`ifdef COEFF_CHECKSUM_EN
  localparam int NW = DEPTH + 1;
`else
  localparam int NW = DEPTH;
`endif

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coeff_table_loader_if #(.DATA_W(DW)) bus();
  coeff_table_loader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int            vec_cnt  = 0;
  int            err_cnt  = 0;
  int            done_cnt = 0;
  int            cyc;
  int            done_before;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wq [$];
  pend_t         pend_q [$];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Appends the checksum word (when enabled), optionally corrupted by +1
  task automatic add_sum(input bit corrupt);
`ifdef COEFF_CHECKSUM_EN
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + wq[i];
    wq.push_back(corrupt ? s + 32'd1 : s);
`else
    if (corrupt) wq.push_back(32'd0);
`endif
  endtask

  task automatic pulse_start(input bit with_word);
    bus.start   = 1'b1;
    bus.s_valid = with_word;
    bus.s_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    pend_q.delete();
  endtask

  task automatic feed(input int n, input bit bp, input bit final_done, output int cycles);
    int idx;
    bit v;
    pend_t e;
    idx    = 0;
    cycles = 0;
    while (idx < n && cycles < 500) begin
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = wq[idx];
      @(negedge clk);
      if (v && bus.s_ready === 1'b1) begin
        if (idx < DEPTH) begin
          e.addr = 6'(idx);
          e.data = wq[idx];
          pend_q.push_back(e);
          bus.rd_addr = 6'(idx);
        end
        idx++;
        @(posedge clk); #1;
        cycles++;
        if (idx <= DEPTH) check_val("wr_then_rd", bus.rd_data, wq[idx-1]);
        check_val("done_timing", 32'(bus.done), (idx == n) ? 32'(final_done) : 32'd0);
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    bus.s_valid = 1'b0;
    check_val("feed_count", idx, n);
  endtask

  task automatic verify_table();
    pend_t e;
    while (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      model[e.addr[3:0]] = e.data;
    end
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = 6'(a);
      #1;
      check_val("table_rd", bus.rd_data, model[a]);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_table_valid", 32'(bus.table_valid), 32'd0);
    check_val("rst_chk_err", 32'(bus.chk_err), 32'd0);
    bus.rd_addr = 6'd0;  #1; check_val("rst_rd0", bus.rd_data, 32'd0);
    bus.rd_addr = 6'd7;  #1; check_val("rst_rd7", bus.rd_data, 32'd0);
    bus.rd_addr = 6'd15; #1; check_val("rst_rd15", bus.rd_data, 32'd0);
    bus.rd_addr = 6'd63; #1; check_val("rst_rd63", bus.rd_data, 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.rd_addr = 6'd0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state();

    // Full back-to-back load
    wq = '{32'h0000, 32'h0644, 32'h0C89, 32'h1000, 32'h1300, 32'h1600, 32'h1900, 32'h1C00,
           32'h1F00, 32'h2200, 32'h2400, 32'h2600, 32'h2800, 32'h2A00, 32'h2B60, 32'hFFFF};
    add_sum(1'b0);
    done_before = done_cnt;
    @(posedge clk); #1;
    pulse_start(1'b0);
    feed(NW, 1'b0, 1'b1, cyc);
    check_val("full_cycles", cyc, NW);
    check_val("full_table_valid", 32'(bus.table_valid), 32'd1);
    check_val("full_chk_err", 32'(bus.chk_err), 32'd0);
    check_val("full_busy_after", 32'(bus.busy), 32'd0);
    check_val("full_ready_after", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    check_val("full_done_one_cycle", 32'(bus.done), 32'd0);
    check_val("full_done_count", done_cnt - done_before, 1);
    verify_table();
    bus.rd_addr = 6'd1;  #1; check_val("full_rd1", bus.rd_data, 32'h0644);
    bus.rd_addr = 6'd15; #1; check_val("full_rd15", bus.rd_data, 32'hFFFF);

    // Out-of-range reads
    bus.rd_addr = 6'd16; #1; check_val("oor_16", bus.rd_data, 32'd0);
    bus.rd_addr = 6'd32; #1; check_val("oor_32", bus.rd_data, 32'd0);
    bus.rd_addr = 6'd63; #1; check_val("oor_63", bus.rd_data, 32'd0);

    // Start from a valid table, then a backpressured load
    @(posedge clk); #1;
    pulse_start(1'b0);
    check_val("idle_start_tv_drop", 32'(bus.table_valid), 32'd0);
    check_val("idle_start_busy", 32'(bus.busy), 32'd1);
    bus.rd_addr = 6'd1; #1; check_val("idle_start_rd_kept", bus.rd_data, 32'h0644);
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
    add_sum(1'b0);
    done_before = done_cnt;
    feed(NW, 1'b1, 1'b1, cyc);
    check_val("bp_table_valid", 32'(bus.table_valid), 32'd1);
    @(posedge clk); #1;
    check_val("bp_done_count", done_cnt - done_before, 1);
    verify_table();

    // Restart after 5 words; the start cycle carries a word that must be dropped
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
    done_before = done_cnt;
    pulse_start(1'b0);
    feed(5, 1'b0, 1'b0, cyc);
    pulse_start(1'b1);
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'h00A0 + 32'(i));
    add_sum(1'b0);
    feed(NW, 1'b0, 1'b1, cyc);
    check_val("restart_cycles", cyc, NW);
    @(posedge clk); #1;
    check_val("restart_done_count", done_cnt - done_before, 1);
    verify_table();
    bus.rd_addr = 6'd5; #1; check_val("restart_rd5", bus.rd_data, 32'h00A5);

`ifdef COEFF_CHECKSUM_EN
    // Corrupted checksum word
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
    add_sum(1'b1);
    done_before = done_cnt;
    pulse_start(1'b0);
    feed(NW, 1'b0, 1'b1, cyc);
    check_val("bad_sum_chk_err", 32'(bus.chk_err), 32'd1);
    check_val("bad_sum_table_valid", 32'(bus.table_valid), 32'd0);
    @(posedge clk); #1;
    check_val("bad_sum_done_count", done_cnt - done_before, 1);
    check_val("bad_sum_err_sticky", 32'(bus.chk_err), 32'd1);
    verify_table();
`endif

    // Reset during a load aborts without a done pulse
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
    done_before = done_cnt;
    pulse_start(1'b0);
    check_val("restart_clears_err", 32'(bus.chk_err), 32'd0);
    feed(7, 1'b0, 1'b0, cyc);
    rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("midrst_no_done", done_cnt - done_before, 0);
    check_val("midrst_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/coeff_table_loader.md
# coeff_table_loader

Writable coefficient table for the piecewise function-approximation datapath: the write-side counterpart of the read-only coefficient LUT. It accepts a burst of segment coefficients over a valid/ready stream, stores them in a 16-entry register file, and serves them to the approximation evaluator through a combinational read port using the same 6-bit segment address. The table is marked valid only after a complete, uninterrupted load, so coefficients can be reprogrammed at run time without resynthesis.

## Interface
- DEPTH, 16, number of segment coefficients.
- DATA_W, 32, coefficient width.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a table load.
- s_valid  input  1  coefficient word present on s_data.
- s_data  input  DATA_W  coefficient word; segment order 0..DEPTH-1.
- s_ready  output  1  loader accepts a word this cycle.
- rd_addr  input  6  segment address from the evaluator.
- rd_data  output  DATA_W  coefficient at rd_addr; combinational.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes.
- table_valid  output  1  table holds a complete, accepted load.
- chk_err  output  1  checksum mismatch on the last load; sticky until next start or reset.

## Operation
- States: IDLE, LOAD, CHECK (CHECK exists only with COEFF_CHECKSUM_EN).
- IDLE: s_ready=0, busy=0. start -> LOAD; wr_ptr<=0; table_valid<=0; chk_err<=0.
- LOAD: s_ready=1, busy=1. Handshake = s_valid & s_ready; each handshake writes mem[wr_ptr]<=s_data, wr_ptr<=wr_ptr+1. Cycles with s_valid=0 leave state and wr_ptr unchanged.
- Handshake with wr_ptr==DEPTH-1 writes the last entry, then: without checksum -> IDLE, done=1 and table_valid=1 next cycle; with checksum -> CHECK.
- start asserted in LOAD or CHECK: restart, wr_ptr<=0, entries already written are kept but overwritten by the new burst; any handshake in that same cycle is ignored (start wins).
- start in IDLE with table_valid=1: table_valid drops the following cycle; rd_data still returns stored entries.
- Reads: rd_addr<DEPTH -> rd_data=mem[rd_addr]; rd_addr>=DEPTH (upper bits set) -> rd_data=0. Reads are never blocked; reading during LOAD returns partially updated contents.
- Write-then-read of same address: new value appears on rd_data the cycle after the handshake edge.
- Reset: all mem entries 0, wr_ptr=0, state IDLE.

## Timing
- Reset values: s_ready=0, busy=0, done=0, table_valid=0, chk_err=0, rd_data=0 for any rd_addr.
- s_ready and busy decode registered state only; no combinational path from s_valid to s_ready.
- Peak throughput: one word per cycle; minimum load = DEPTH cycles after the cycle following start (DEPTH+1 with checksum).
- done asserted exactly one cycle, on the cycle after the final handshake; table_valid rises on the same cycle and holds.
- rd_addr -> rd_data zero-cycle latency.
- Reset asserted mid-load aborts immediately; no done pulse.

## Configuration
- COEFF_CHECKSUM_EN defined: after the DEPTH coefficients, LOAD->CHECK accepts one additional word (s_ready=1) = expected 32-bit sum, modulo 2^32, of all DEPTH words. Handshake in CHECK: match -> table_valid=1, done=1; mismatch -> chk_err=1, done=1, table_valid stays 0. Returns to IDLE either way.
- COEFF_CHECKSUM_EN undefined: no CHECK state, no checksum word, chk_err tied 0.

## Test plan
- Reset: assert rst mid-simulation -> all outputs 0, rd_data=0 at addresses 0, 7, 15, 63.
- Full load: start, then 16 back-to-back words 0x0, 0x644, 0xC89, ..., 0x2B60, 0xFFFF -> done pulse on cycle 17 after start, table_valid=1, rd_addr=1 returns 0x644, rd_addr=15 returns 0xFFFF.
- Backpressure: s_valid toggled 1-0-1 randomly -> exactly 16 writes, correct order, done only after 16th handshake.
- Restart: start after 5 words, then 16 new words 0xA0..0xAF -> entries 0..15 = 0xA0..0xAF, one done pulse.
- Out of range: rd_addr=16, 32, 63 -> rd_data=0.
- With COEFF_CHECKSUM_EN: correct sum -> table_valid=1, chk_err=0; sum+1 -> chk_err=1, table_valid=0, done still pulses once.
